frame_feedback_dma: RTL and testbench

- Hardware replacement for the bench-only feedback copy between the two frame stores.
- Reads the interleaved BGR byte buffer filled by the image writer through a synchronous read port.
- Writes planar R/G/B pixel memory consumed by the image reader, one pixel per write, with a start/busy/done handshake.
- Lets a processed frame be fed back for another filter pass without testbench hierarchy access.

---
 rtl/frame_feedback_dma.sv | 162 ++++++++++++++++
 tb/tb_frame_feedback_dma.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_feedback_dma.sv
// frame_feedback_dma: copies an interleaved BGR byte buffer into planar R/G/B pixel memory,
// one pixel per write, under a start/busy/done handshake.
// Optional build macro FEEDBACK_GRAY_EN: writes a luma-like gray value (R + 2G + B) >> 2
// to all three components instead of copying them unchanged.
module frame_feedback_dma #(
  parameter int unsigned IMG_W   = 768,
  parameter int unsigned IMG_H   = 512,
  parameter int unsigned PIX_AW  = 19,
  parameter int unsigned BYTE_AW = 21
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic               SRC_RD,
  output logic [BYTE_AW-1:0] SRC_ADDR,
  input  logic [7:0]         SRC_DATA,
  output logic               DST_WE,
  input  logic               DST_READY,
  output logic [PIX_AW-1:0]  DST_ADDR,
  output logic [7:0]         DST_R,
  output logic [7:0]         DST_G,
  output logic [7:0]         DST_B
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam logic [PIX_AW-1:0] LAST_K = PIX_AW'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    LAT,
    WR,
    FIN
  } state_t;

  state_t             state;
  logic [PIX_AW-1:0]  k;
  logic [7:0]         b_byte;
  logic [7:0]         g_byte;

  logic [PIX_AW-1:0]  k_inc;
  logic [BYTE_AW-1:0] k_ext;
  logic [BYTE_AW-1:0] k_inc_ext;
  logic [BYTE_AW-1:0] addr_3k;
  logic [BYTE_AW-1:0] addr_3k_next;
  logic [7:0]         pix_r;
  logic [7:0]         pix_g;
  logic [7:0]         pix_b;

  // Byte addresses for the current and the following pixel; 3k as (k<<1)+k at byte width
  always_comb begin
    k_inc        = k + PIX_AW'(1);
    k_ext        = BYTE_AW'(k);
    k_inc_ext    = BYTE_AW'(k_inc);
    addr_3k      = (k_ext << 1) + k_ext;
    addr_3k_next = (k_inc_ext << 1) + k_inc_ext;
  end

`ifdef FEEDBACK_GRAY_EN
  logic [9:0] gray_sum;
  logic       gray_unused;

  // Gray value from the two captured bytes and the R byte arriving this cycle
  always_comb begin
    gray_sum    = {2'b00, SRC_DATA} + {1'b0, g_byte, 1'b0} + {2'b00, b_byte};
    pix_r       = gray_sum[9:2];
    pix_g       = gray_sum[9:2];
    pix_b       = gray_sum[9:2];
    gray_unused = ^gray_sum[1:0];
  end
`else
  // Straight copy; R is taken directly off the read bus as it arrives in LAT
  always_comb begin
    pix_r = SRC_DATA;
    pix_g = g_byte;
    pix_b = b_byte;
  end
`endif

  // Copy sequencer: every output is registered and loaded on the transition into its state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= IDLE;
      k        <= '0;
      b_byte   <= '0;
      g_byte   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SRC_RD   <= 1'b0;
      SRC_ADDR <= '0;
      DST_WE   <= 1'b0;
      DST_ADDR <= '0;
      DST_R    <= '0;
      DST_G    <= '0;
      DST_B    <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state    <= RD0;
            k        <= '0;
            BUSY     <= 1'b1;
            SRC_RD   <= 1'b1;
            SRC_ADDR <= '0;
            DST_ADDR <= '0;
          end
        end
        RD0: begin
          state    <= RD1;
          SRC_ADDR <= addr_3k + BYTE_AW'(1);
        end
        RD1: begin
          // Data for the RD0 address (B) is on the bus now
          b_byte   <= SRC_DATA;
          state    <= RD2;
          SRC_ADDR <= addr_3k + BYTE_AW'(2);
        end
        RD2: begin
          g_byte <= SRC_DATA;
          SRC_RD <= 1'b0;
          state  <= LAT;
        end
        LAT: begin
          DST_WE <= 1'b1;
          DST_R  <= pix_r;
          DST_G  <= pix_g;
          DST_B  <= pix_b;
          state  <= WR;
        end
        WR: begin
          // Hold the write request and data until the destination accepts it
          if (DST_READY) begin
            DST_WE <= 1'b0;
            if (k == LAST_K) begin
              state <= FIN;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              k        <= k_inc;
              DST_ADDR <= k_inc;
              SRC_RD   <= 1'b1;
              SRC_ADDR <= addr_3k_next;
              state    <= RD0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_feedback_dma.sv
// Bench for frame_feedback_dma on a 4x2 frame: directed handshake cases plus random frames
// with random destination back-pressure, checked against a per-pixel reference model.
`timescale 1ns/1ps
module tb_frame_feedback_dma;

  localparam int unsigned IMG_W   = 4;
  localparam int unsigned IMG_H   = 2;
  localparam int unsigned PIX_AW  = 3;
  localparam int unsigned BYTE_AW = 5;
  localparam int          NPIX    = IMG_W * IMG_H;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic               START;
  logic               BUSY;
  logic               DONE;
  logic               SRC_RD;
  logic [BYTE_AW-1:0] SRC_ADDR;
  logic [7:0]         SRC_DATA = 8'h00;
  logic               DST_WE;
  logic               DST_READY = 1'b1;
  logic [PIX_AW-1:0]  DST_ADDR;
  logic [7:0]         DST_R;
  logic [7:0]         DST_G;
  logic [7:0]         DST_B;

  frame_feedback_dma #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_AW (PIX_AW),
    .BYTE_AW(BYTE_AW)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .START    (START),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SRC_RD   (SRC_RD),
    .SRC_ADDR (SRC_ADDR),
    .SRC_DATA (SRC_DATA),
    .DST_WE   (DST_WE),
    .DST_READY(DST_READY),
    .DST_ADDR (DST_ADDR),
    .DST_R    (DST_R),
    .DST_G    (DST_G),
    .DST_B    (DST_B)
  );

  always #5 HCLK = ~HCLK;

  // Interleaved source buffer: data appears one cycle after the read strobe
  logic [7:0] mem [32];
  always @(posedge HCLK) if (SRC_RD) SRC_DATA <= mem[SRC_ADDR];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected pixel k as {R,G,B} straight from the byte layout B,G,R at 3k..3k+2
  function automatic logic [23:0] exp_pix(input int k);
    int b, g, r, s;
    b = mem[3*k];
    g = mem[3*k+1];
    r = mem[3*k+2];
`ifdef FEEDBACK_GRAY_EN
    s = (r + 2*g + b) / 4;
    return {s[7:0], s[7:0], s[7:0]};
`else
    s = 0;
    return {r[7:0], g[7:0], b[7:0]};
`endif
  endfunction

  // Monitor state shared with the stimulus
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stall pixel 3
  int          stall_left = 0;
  int          wr_idx = 0;
  int          stalls = 0;
  int          done_cnt = 0;
  int          rd_viol = 0;
  int          stall_viol = 0;
  bit          prev_stall = 0;
  logic [26:0] prev_vals = '0;

  // Destination driver and write monitor, evaluated once per cycle on the falling edge
  initial begin
    forever begin
      @(negedge HCLK);
      case (ready_mode)
        0: DST_READY = 1'b1;
        1: DST_READY = ($urandom_range(0, 3) != 0);
        default: begin
          if (DST_WE && DST_ADDR == 3'd3 && stall_left > 0) begin
            DST_READY = 1'b0;
            stall_left--;
          end else begin
            DST_READY = 1'b1;
          end
        end
      endcase
      if (HRESET) begin
        wr_idx     = 0;
        prev_stall = 0;
      end else begin
        if (SRC_RD && DST_WE) rd_viol++;
        if (prev_stall && (!DST_WE || {DST_ADDR, DST_R, DST_G, DST_B} != prev_vals)) stall_viol++;
        if (DONE) done_cnt++;
        if (DST_WE && DST_READY) begin
          if (wr_idx < NPIX)
            check("wr_pix", {DST_ADDR, DST_R, DST_G, DST_B}, {3'(wr_idx), exp_pix(wr_idx)});
          else
            check("write_count", wr_idx + 1, NPIX);
          wr_idx++;
        end
        if (DST_WE && !DST_READY) stalls++;
        prev_stall = DST_WE && !DST_READY;
        prev_vals  = {DST_ADDR, DST_R, DST_G, DST_B};
      end
    end
  end

  // One full copy from a START pulse; called right after a falling edge
  task automatic run_frame(input bit pulse_mid, input bit pulse_fin, input int exp_stalls);
    int  c;
    int  d0;
    bit  got;
    logic acc;
    wr_idx = 0;
    stalls = 0;
    rd_viol = 0;
    stall_viol = 0;
    d0 = done_cnt;
    got = 0;
    c = 0;
    START = 1'b1;
    while (!got && c < 400) begin
      @(negedge HCLK);
      c++;
      START = 1'b0;
      if (c <= 3) check("src_seq", {SRC_RD, SRC_ADDR}, {1'b1, 5'(c - 1)});
      if (c == 4) check("src_rd_off_lat", SRC_RD, 1'b0);
      if (pulse_mid && c == 12) START = 1'b1;
      if (DONE) begin
        got = 1;
        check("busy_in_fin", BUSY, 1'b0);
        if (pulse_fin) START = 1'b1;
      end
    end
    check("done_seen", got, 1'b1);
    check("done_cycle", c, 41 + stalls);
    if (exp_stalls >= 0) check("stall_cycles", stalls, exp_stalls);
    acc = 1'b0;
    repeat (10) begin
      @(negedge HCLK);
      START = 1'b0;
      acc = acc | BUSY | SRC_RD | DST_WE;
    end
    check("idle_after_frame", acc, 1'b0);
    check("writes", wr_idx, NPIX);
    check("done_pulses", done_cnt - d0, 1);
    check("rd_during_wr", rd_viol, 0);
    check("stall_stable", stall_viol, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    int   d0;
    logic acc;
    HRESET = 1'b1;
    START  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    repeat (2) @(negedge HCLK);
    check("reset_outputs",
          {BUSY, DONE, SRC_RD, SRC_ADDR, DST_WE, DST_ADDR, DST_R, DST_G, DST_B}, '0);

    HRESET = 1'b0;
    acc = 1'b0;
    repeat (10) begin
      @(negedge HCLK);
      acc = acc | BUSY | SRC_RD;
    end
    check("idle_no_start", acc, 1'b0);

    // Plain frame, always ready
    ready_mode = 0;
    run_frame(1'b0, 1'b0, 0);

    // Back-pressure: seven stall cycles on pixel 3
    ready_mode = 2;
    stall_left = 7;
    run_frame(1'b0, 1'b0, 7);

    // START during pixel 2 and during FIN must not restart
    ready_mode = 0;
    run_frame(1'b1, 1'b1, 0);

    // Reset during WR of pixel 5 aborts without DONE
    c = 0;
    wr_idx = 0;
    START = 1'b1;
    @(negedge HCLK);
    START = 1'b0;
    while (!(DST_WE && DST_ADDR == 3'd5) && c < 200) begin
      @(negedge HCLK);
      c++;
    end
    check("reached_pix5", {DST_WE, DST_ADDR}, {1'b1, 3'd5});
    d0 = done_cnt;
    HRESET = 1'b1;
    #1;
    check("async_reset_outputs",
          {BUSY, DONE, SRC_RD, SRC_ADDR, DST_WE, DST_ADDR, DST_R, DST_G, DST_B}, '0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (5) @(negedge HCLK);
    check("no_done_after_abort", done_cnt - d0, 0);
    run_frame(1'b0, 1'b0, 0);

    // Random frames under random back-pressure; pixel 1 saturated
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[3] = 8'hff;
      mem[4] = 8'hff;
      mem[5] = 8'hff;
      run_frame(1'b0, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
